// File: rtl/data_sram_ctrl.sv
// Data-memory responder: runs a 32-bit load/store as two 16-bit async-SRAM accesses (low half, then high half).
// Latency: 2*WAIT_CYCLES+1 cycles with ready low, then one DONE cycle with ready high and rdata valid.
// Backpressure: ready drops while a request is pending and rises only in DONE; the pipeline freezes on ~ready.
//
// Ports:
//   clk, reset (async, active-low)
//   MEM_R_EN/MEM_W_EN, address, wdata : request from the MEM stage
//   rdata, ready                      : load result and pipeline freeze control
//   SRAM_ADDR, SRAM_WE_N, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_DQ_IN : external SRAM bus
module data_sram_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_IN
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter value on the final cycle of each half access.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_is_wr;
    logic [16:0] r_word;
    logic [15:0] r_wdata_hi;

    logic [31:0] w_off;
    logic [16:0] w_word;
    logic        w_unused;

    // Word index relative to the SRAM window; bits outside [18:2] are dropped.
    assign w_off    = address - 32'(BASE_ADDR);
    assign w_word   = w_off[18:2];
    assign w_unused = ^{w_off[31:19], w_off[1:0]};

    // Combinational so the pipeline freezes in the same cycle the request appears.
    assign ready = ~(MEM_R_EN | MEM_W_EN) | (r_state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_is_wr     <= 1'b0;
            r_word      <= 17'd0;
            r_wdata_hi  <= 16'd0;
            rdata       <= 32'd0;
            SRAM_ADDR   <= 18'd0;
            SRAM_WE_N   <= 1'b1;
            SRAM_DQ_OUT <= 16'd0;
            SRAM_DQ_OE  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (MEM_W_EN | MEM_R_EN) begin
                        // Store takes priority when both enables are high.
                        r_is_wr    <= MEM_W_EN;
                        r_word     <= w_word;
                        r_wdata_hi <= wdata[31:16];
                        r_cnt      <= 4'd0;
                        r_state    <= LOW;
                        SRAM_ADDR  <= {w_word, 1'b0};
                        if (MEM_W_EN) begin
                            SRAM_WE_N   <= 1'b0;
                            SRAM_DQ_OE  <= 1'b1;
                            SRAM_DQ_OUT <= wdata[15:0];
                        end
                    end
                end
                LOW: begin
                    if (r_cnt == LAST_CNT) begin
                        if (!r_is_wr) begin
                            rdata[15:0] <= SRAM_DQ_IN;
                        end else begin
                            SRAM_DQ_OUT <= r_wdata_hi;
                        end
                        r_cnt     <= 4'd0;
                        r_state   <= HIGH;
                        SRAM_ADDR <= {r_word, 1'b1};
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (r_cnt == LAST_CNT) begin
                        if (!r_is_wr) begin
                            rdata[31:16] <= SRAM_DQ_IN;
                        end
                        r_cnt      <= 4'd0;
                        r_state    <= DONE;
                        SRAM_WE_N  <= 1'b1;
                        SRAM_DQ_OE <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
